// File: rtl/dense_ctrl_pkg.sv
// dense_ctrl_pkg: shared types and latency definition for the dense-layer sequencer and datapath
package dense_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_e;

    localparam int CNT_W_DEF = 16;

    // Issue-to-output latency of the dense datapath plus its delay-register stage
    function automatic int dense_latency(input int size);
        return size * 2 - 1;
    endfunction

endpackage

// File: rtl/dense_valid_pipe.sv
// dense_valid_pipe: depth-stage {valid, tag} shift register tracking vectors through the datapath
module dense_valid_pipe #(
    parameter int depth = 5,
    parameter int tag_w = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [tag_w-1:0] in_tag,
    output logic             out_valid,
    output logic [tag_w-1:0] out_tag
);

    logic [depth-1:0]       valid_q, valid_d;
    logic [depth*tag_w-1:0] tag_q, tag_d;

    // Shift one stage per clock; flush only needs to kill the valid bits
    always_comb begin
        valid_d = flush ? '0 : depth'({valid_q, in_valid});
        tag_d   = (depth*tag_w)'({tag_q, in_tag});
    end

    // Pipeline registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
        end
    end

    assign out_valid = valid_q[depth-1];
    assign out_tag   = tag_q[depth*tag_w-1 -: tag_w];

endmodule

// File: rtl/dense_layer_seq_ctrl.sv
// dense_layer_seq_ctrl: sequences one dense-layer pass, gating issue and tracking results to retirement
module dense_layer_seq_ctrl
    import dense_ctrl_pkg::*;
#(
    parameter int size            = 3,
    parameter int cycle           = dense_latency(size),
    parameter int dense_type_size = 4,
    parameter int cnt_w           = CNT_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [cnt_w-1:0]           batch_len,
    input  logic [dense_type_size-1:0] dense_type_cfg,
    input  logic                       abort,
    input  logic                       in_valid,
    output logic                       in_ready,
    output logic                       issue,
    output logic [cnt_w-1:0]           issue_tag,
    output logic [dense_type_size-1:0] dense_type_out,
    output logic                       out_valid,
    output logic [cnt_w-1:0]           out_tag,
    output logic                       busy,
    output logic                       done
);

    state_e                     state_q, state_d;
    logic [cnt_w-1:0]           issued_q, issued_d;
    logic [cnt_w-1:0]           retired_q, retired_d;
    logic [cnt_w-1:0]           len_q, len_d;
    logic [dense_type_size-1:0] type_q, type_d;
    logic                       start_acc, flush, clr;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next state: abort wins everywhere outside IDLE; DRAIN exits as the last result retires
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (batch_len == '0) ? DONE : STREAM;
            STREAM:  if (abort) state_d = IDLE;
                     else if (issue && issued_q == len_q - 1'b1) state_d = DRAIN;
            DRAIN:   if (abort) state_d = IDLE;
                     else if (retired_d == len_q) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs; abort drops in_ready so a coincident handshake is never issued
    always_comb begin
        in_ready = (state_q == STREAM) && !abort;
        issue    = in_valid && in_ready;
        busy     = state_q != IDLE;
        done     = state_q == DONE;
    end

    // Counter and latch updates; counters restart on every accepted start, abort and completion
    always_comb begin
        start_acc = (state_q == IDLE) && start;
        flush     = abort && (state_q != IDLE);
        clr       = start_acc || flush || (state_q == DONE);
        issued_d  = clr ? '0 : issued_q + cnt_w'(issue);
        retired_d = clr ? '0 : retired_q + cnt_w'(out_valid);
        len_d     = start_acc ? batch_len : len_q;
        type_d    = start_acc ? dense_type_cfg : type_q;
    end

    // Counter and configuration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q  <= '0;
            retired_q <= '0;
            len_q     <= '0;
            type_q    <= '0;
        end else begin
            issued_q  <= issued_d;
            retired_q <= retired_d;
            len_q     <= len_d;
            type_q    <= type_d;
        end
    end

    assign issue_tag      = issued_q;
    assign dense_type_out = type_q;

    dense_valid_pipe #(
        .depth (cycle),
        .tag_w (cnt_w)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (issue),
        .in_tag    (issue_tag),
        .out_valid (out_valid),
        .out_tag   (out_tag)
    );

endmodule

// File: tb/tb_dense_layer_seq_ctrl.sv
// tb_dense_layer_seq_ctrl: directed cycle-by-cycle checks of the dense-layer sequencer
module tb_dense_layer_seq_ctrl;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic [15:0] batch_len = 0;
    logic [3:0]  dense_type_cfg = 0;
    logic        abort = 0;
    logic        in_valid = 0;
    logic        in_ready, issue, out_valid, busy, done;
    logic [15:0] issue_tag, out_tag;
    logic [3:0]  dense_type_out;
    int          n_cmp = 0;
    int          n_bad = 0;

    dense_layer_seq_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .batch_len      (batch_len),
        .dense_type_cfg (dense_type_cfg),
        .abort          (abort),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .issue          (issue),
        .issue_tag      (issue_tag),
        .dense_type_out (dense_type_out),
        .out_valid      (out_valid),
        .out_tag        (out_tag),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_issue"}, issue, 0);
        check({tag, "_in_ready"}, in_ready, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_tag"}, out_tag, 0);
        check({tag, "_issue_tag"}, issue_tag, 0);
        check({tag, "_type"}, dense_type_out, 0);
    endtask

    task automatic do_start(input logic [15:0] len, input logic [3:0] typ);
        start = 1;
        batch_len = len;
        dense_type_cfg = typ;
        in_valid = 0;
        abort = 0;
        #1;
        check("start_idle_busy", busy, 0);
        @(posedge clk);
        #1;
        start = 0;
    endtask

    // Cycle 0 is the first cycle after the accepted start; tags are expected in issue order
    task automatic run_pass(input string name, input int n, input logic [31:0] vin, input logic [31:0] smask,
                            input logic [31:0] amask, input logic [31:0] iss, input logic [31:0] outm,
                            input logic [31:0] dn, input logic [31:0] bsy, input logic [3:0] typ);
        int icnt = 0;
        int ocnt = 0;
        for (int c = 0; c < n; c++) begin
            in_valid = vin[c];
            start = smask[c];
            batch_len = smask[c] ? 16'd9 : batch_len;
            dense_type_cfg = smask[c] ? ~typ : dense_type_cfg;
            abort = amask[c];
            #1;
            check({name, "_issue"}, issue, iss[c]);
            check({name, "_out_valid"}, out_valid, outm[c]);
            check({name, "_done"}, done, dn[c]);
            check({name, "_busy"}, busy, bsy[c]);
            if (iss[c]) check({name, "_issue_tag"}, issue_tag, icnt);
            if (outm[c]) check({name, "_out_tag"}, out_tag, ocnt);
            if (bsy[c]) check({name, "_type"}, dense_type_out, typ);
            icnt += int'(iss[c]);
            ocnt += int'(outm[c]);
            @(posedge clk);
            #1;
        end
        in_valid = 0;
        start = 0;
        abort = 0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        #3 rst_n = 1;
        @(posedge clk);
        #1;
        check("post_reset_busy", busy, 0);

        do_start(16'd4, 4'h5);
        run_pass("b2b", 11, 32'hFFFF_FFFF, 0, 0, 32'h0F, 32'h1E0, 32'h200, 32'h3FF, 4'h5);

        do_start(16'd3, 4'h6);
        run_pass("bubble", 12, 32'b11001, 0, 0, 32'b11001, 32'h320, 32'h400, 32'h7FF, 4'h6);

        do_start(16'd0, 4'h7);
        run_pass("zero", 3, 0, 0, 0, 0, 0, 32'h1, 32'h1, 4'h7);

        do_start(16'd4, 4'h8);
        run_pass("abort", 10, 32'hFFFF_FFFF, 0, 32'h20, 32'h0F, 32'h20, 0, 32'h3F, 4'h8);
        do_start(16'd2, 4'h2);
        run_pass("after_abort", 9, 32'hFFFF_FFFF, 0, 0, 32'h03, 32'h60, 32'h80, 32'hFF, 4'h2);

        do_start(16'd4, 4'hA);
        run_pass("busy_start", 11, 32'hFFFF_FFFF, 32'h02, 0, 32'h0F, 32'h1E0, 32'h200, 32'h3FF, 4'hA);

        do_start(16'd4, 4'h3);
        run_pass("pre_rst", 2, 32'hFFFF_FFFF, 0, 0, 32'h03, 0, 0, 32'h03, 4'h3);
        in_valid = 1;
        #2 rst_n = 0;
        #1;
        check_all_zero("async_rst");
        #2 rst_n = 1;
        in_valid = 0;
        @(posedge clk);
        #1;
        check("rst_release_busy", busy, 0);
        check("rst_release_out_valid", out_valid, 0);
        do_start(16'd1, 4'h9);
        run_pass("after_rst", 8, 32'hFFFF_FFFF, 0, 0, 32'h01, 32'h20, 32'h40, 32'h7F, 4'h9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dense_layer_seq_ctrl.md
Name: dense_layer_seq_ctrl

Overview:
Sequencer for one dense-layer pass through the fixed-latency dense datapath and its delay-register stage. It accepts a start command with a vector count, admits x/w vectors from the upstream source with a valid/ready handshake, and tracks each issued vector through the cycle-deep pipeline. It emits an output-valid strobe and tag aligned with the datapath output, and a done pulse when the last result has retired.
- The datapath has no stall input: it advances every clock, so this block only gates what enters it.

Parameters:
- size, 3, vector length of the dense datapath.
- cycle, size*2-1, pipeline latency in clocks from issue to aligned output; must be >= 1.
- dense_type_size, 4, width of the dense-type field.
- cnt_w, 16, width of the vector count and tag.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle command; honoured only in IDLE.
- batch_len  in  cnt_w  number of vectors in the pass; sampled on an accepted start.
- dense_type_cfg  in  dense_type_size  layer type; sampled on an accepted start.
- abort  in  1  cancels the pass and flushes tracking state.
- in_valid  in  1  upstream vector available.
- in_ready  out  1  block accepts a vector this cycle.
- issue  out  1  vector enters the datapath this cycle; equals in_valid & in_ready.
- issue_tag  out  cnt_w  index of the issued vector, 0..batch_len-1.
- dense_type_out  out  dense_type_size  latched type, driven to the datapath.
- out_valid  out  1  datapath output is valid this cycle.
- out_tag  out  cnt_w  index of the retiring vector.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when the pass completes.

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0; valid/tag pipeline cleared.
- FSM states: IDLE, STREAM, DRAIN, DONE.
- IDLE, start=1, batch_len>0: latch batch_len and dense_type_cfg; go to STREAM.
- IDLE, start=1, batch_len=0: go to DONE directly; no issue occurs.
- STREAM: in_ready=1. Each handshake asserts issue, drives issue_tag = issued count, then increments the issued count. The handshake that issues vector batch_len-1 moves the FSM to DRAIN in the same edge.
- DRAIN: in_ready=0. Remain until the retired count equals batch_len, then go to DONE.
- DONE: done=1 for exactly one cycle; next state IDLE; busy drops in that IDLE cycle.
- Tracking pipeline:
  - A cycle-deep shift of {valid, tag} advances every clock.
  - Stage 0 loads {issue, issue_tag}.
  - out_valid/out_tag are the last stage, so a vector issued at edge N retires at edge N+cycle.
  - The retired count increments on each out_valid.
- Stalls: in_valid=0 inserts a bubble (valid=0) into the pipeline. out_valid gaps mirror issue gaps exactly.
- start while busy: ignored, with no effect on any counter or latch.
- abort (any non-IDLE state):
  - Next state IDLE; counters cleared; all pipeline valid bits cleared; no done pulse.
  - Abort has priority over a simultaneous handshake, which is not issued (issue=0).
  - In IDLE, abort has no effect.
- Simultaneous issue and retire in one cycle: both counters update independently.
- Widths: counters and tags are cnt_w bits. The maximum batch is 2^cnt_w-1; no wrap is possible within a pass.
- Asynchronous reset mid-pass: immediate return to reset values. The datapath contents become don't-care, since out_valid is 0.

Decomposition:
- Shared package dense_ctrl_pkg holds:
  - the FSM state enum (IDLE, STREAM, DRAIN, DONE);
  - the default cnt_w;
  - a latency function returning size*2-1, so this block and the delay-register stage share one definition.
- One sub-module: dense_valid_pipe, parameterised by depth and tag width. It is a shift register of {valid, tag} with a synchronous flush input and asynchronous active-low reset.

Test Plan:
- Back-to-back batch (size=3, cycle=5, batch_len=4, in_valid held high): issue in 4 consecutive cycles with tags 0..3. out_valid follows 5 cycles after each issue with tags 0..3. done pulses the cycle after tag 3 retires. busy is high from the cycle after start until done.
- Bubbles (batch_len=3, in_valid pattern 1,0,0,1,1): issues at cycles 0, 3 and 4. out_valid at cycles 5, 8 and 9 with tags 0, 1 and 2. No out_valid at cycles 6 and 7.
- Zero length (start with batch_len=0): DONE in the next cycle; exactly one done pulse; no issue or out_valid.
- Abort mid-drain (batch_len=4; assert abort 2 cycles after the last issue): next cycle IDLE. No further out_valid, even though vectors are still in flight. No done pulse. A fresh start with batch_len=2 completes normally with tags 0 and 1.
- start while busy (second start during STREAM with batch_len=9): ignored; the pass still completes with the original batch_len of 4.
- Async reset (assert rst_n=0 mid-STREAM between clock edges): all outputs 0 immediately. After release, the block sits in IDLE and accepts a new start.
